mux8_rr_arbiter: RTL and testbench
==================================

MUX8_RR_ARBITER -- requirements
Module: mux8_rr_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 4, maximum consecutive grant cycles while other requests are pending (legal range 1..15).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  8  per-requester request; bit i = requester i.
REQ-005 last  input  1  the granted requester's final beat; ignored when no grant is active.
REQ-006 I  input  8  shared data lines; bit i is driven by requester i.
REQ-007 grant  output  8  one-hot grant, registered; all zeros when idle.
REQ-008 S  output  3  select driven to the 8:1 mux, registered; equals the index of the granted requester.
REQ-009 Y  output  1  registered mux output, I[S] sampled at each edge while a grant is active.
REQ-010 y_valid  output  1  marks Y as carrying granted data.

Function
REQ-011 States SHALL be IDLE and GRANT.
REQ-012 In IDLE with req==0, the block SHALL remain in IDLE with grant=0, and S SHALL hold its last value.
REQ-013 In IDLE with req!=0, the winner SHALL be the first set bit at or after ptr, searching ptr, ptr+1, ..., wrapping 7->0.
  - grant and S SHALL update at the same edge.
  - The block SHALL enter GRANT with latency 1 cycle from the req sample.
REQ-014 At the edge that registers a winner w, ptr SHALL become (w+1) mod 8, so w gets lowest priority next.
REQ-015 In GRANT, grant and S SHALL stay constant until release.
REQ-016 hold_cnt SHALL start at 1 on the granted cycle and increment each GRANT cycle.
REQ-017 Release SHALL occur at the end of any GRANT cycle where:
  - (a) last==1, or
  - (b) req[S]==0, or
  - (c) hold_cnt==HOLD_MAX and another req bit is set.
REQ-018 On release with req (excluding the released requester if it raised last or dropped req) nonzero:
  - the block SHALL re-arbitrate in the same cycle per REQ-013/014;
  - the next grant SHALL appear at the next edge (back-to-back, no idle cycle).
REQ-019 On release with nothing pending, the block SHALL go to IDLE and grant SHALL be 0 at the next edge.
REQ-020 When hold_cnt reaches HOLD_MAX with no other request, the grant SHALL continue and hold_cnt SHALL reload to 1.
REQ-021 While in GRANT, each edge SHALL register Y=I[S] and y_valid=1.
  - Y therefore trails grant by one cycle.
  - y_valid SHALL fall one cycle after grant falls.
REQ-022 grant SHALL never have more than one bit set; S SHALL always equal the index of the set grant bit when grant!=0.
REQ-023 Requests arriving mid-grant SHALL NOT preempt the grant; they are served only at release.

Reset
REQ-024 rst_n low SHALL immediately force:
  - state=IDLE, grant=0, S=0, Y=0, y_valid=0;
  - ptr=0, hold_cnt=0.
REQ-025 Assertion of rst_n mid-grant SHALL abort the grant with no completion beat.
REQ-026 Deassertion SHALL be honored at the next clock edge; the first arbitration after reset favours requester 0.

Structure
REQ-027 Package mux8_arb_pkg SHALL hold:
  - N_REQ=8 and SEL_W=3;
  - the IDLE/GRANT state enum;
  - the hold counter width constant.
REQ-028 Sub-module rr_pick (combinational rotating-priority finder: req, ptr -> one-hot winner, index, any) SHALL be used for arbitration.
REQ-029 The existing mux_8x1 SHALL be instantiated for the I->Y selection ahead of the Y register.

Verification
REQ-030 Reset/idle: rst_n=0 then req=0 for 5 cycles -> grant=00000000, S=000, y_valid=0 throughout.
REQ-031 Single requester: req=00000100 after reset, I=10101010 -> the following SHALL hold:
  - next edge: grant=00000100, S=010;
  - one cycle later: Y=0, y_valid=1.
REQ-032 Round-robin: req=10000001 held, last pulsed each grant cycle -> grants alternate 00000001, 10000000, 00000001, with no idle cycles.
REQ-033 Hold limit: HOLD_MAX=4, req=00000011, last=0 -> requester 0 is granted 4 cycles, then requester 1 for 4 cycles, and so on alternating.
REQ-034 Lone long holder: req=00001000, last=0 for 10 cycles -> grant=00001000 stays continuously; hold_cnt reloads after 4.
REQ-035 Reset mid-grant: rst_n low during grant=00100000 -> grant=0 and y_valid=0 with no clock edge; after release with req=11111111, the first grant is 00000001.

Source files
------------

// File: rtl/mux8_arb_pkg.sv
// Shared constants and state type for the 8-way round-robin arbiter and its
// output mux.
package mux8_arb_pkg;

    localparam int N_REQ  = 8;
    localparam int SEL_W  = 3;
    localparam int HOLD_W = 4;   // holds HOLD_MAX values up to 15

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mux8_arb_rr_pick.sv
// Rotating-priority finder: the first set request at or after ptr, wrapping
// from 7 back to 0. The result is one-hot, plus its index and an any flag.
module rr_pick
    import mux8_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [SEL_W-1:0] pos;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // The 3-bit add wraps naturally, which produces the 7 -> 0 rotation.
            pos = ptr + SEL_W'(i);
            if (!any && req[pos]) begin
                any         = 1'b1;
                idx         = pos;
                onehot[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_8x1.sv
// Plain combinational 8:1 single-bit multiplexer.
module mux_8x1
    import mux8_arb_pkg::*;
(
    input  logic [N_REQ-1:0] d,
    input  logic [SEL_W-1:0] sel,
    output logic             y
);

    assign y = d[sel];

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter over 8 requesters, with a hold limit. It drives a
// registered select into an 8:1 mux and registers the mux output.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    input  logic              last,
    input  logic [N_REQ-1:0]  I,
    output logic [N_REQ-1:0]  grant,
    output logic [SEL_W-1:0]  S,
    output logic              Y,
    output logic              y_valid,
    output logic              state_dbg,
    output logic [HOLD_W-1:0] hold_cnt_dbg
);

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(HOLD_MAX);

    arb_state_e        state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [SEL_W-1:0]  sel_q,   sel_d;
    logic [SEL_W-1:0]  ptr_q,   ptr_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic              y_q,     y_d;
    logic              y_valid_q, y_valid_d;

    logic              mux_y;
    logic              drop_current;
    logic              others_pending;
    logic              at_max;
    logic              release_now;
    logic [N_REQ-1:0]  pick_mask;
    logic [N_REQ-1:0]  pick_onehot;
    logic [SEL_W-1:0]  pick_idx;
    logic              pick_any;

    assign drop_current   = last | ~req[sel_q];
    assign others_pending = |(req & ~grant_q);
    assign at_max         = (hold_q == HOLD_LIMIT);
    assign release_now    = drop_current | (at_max & others_pending);

    // A holder that finished or withdrew must not win the re-arbitration in
    // the same cycle. A holder released by the hold limit stays eligible, but
    // its ptr position already ranks it last.
    assign pick_mask = (state_q == GRANT && drop_current) ? (req & ~grant_q) : req;

    rr_pick u_pick (
        .req    (pick_mask),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    mux_8x1 u_mux (
        .d   (I),
        .sel (sel_q),
        .y   (mux_y)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        y_d       = y_q;
        y_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (pick_any) begin
                    state_d = GRANT;
                    grant_d = pick_onehot;
                    sel_d   = pick_idx;
                    ptr_d   = pick_idx + SEL_W'(1);
                    hold_d  = HOLD_W'(1);
                end
            end
            GRANT: begin
                y_d       = mux_y;
                y_valid_d = 1'b1;
                if (release_now) begin
                    if (pick_any) begin
                        grant_d = pick_onehot;
                        sel_d   = pick_idx;
                        ptr_d   = pick_idx + SEL_W'(1);
                        hold_d  = HOLD_W'(1);
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        hold_d  = '0;
                    end
                end else if (at_max) begin
                    hold_d = HOLD_W'(1);
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            y_q       <= 1'b0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    // y_valid qualifies Y on the same cycle. There is no back-pressure, so
    // every cycle with y_valid high carries one granted sample.
    assign grant        = grant_q;
    assign S            = sel_q;
    assign Y            = y_q;
    assign y_valid      = y_valid_q;
    assign state_dbg    = state_q;
    assign hold_cnt_dbg = hold_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: directed vector table, multi-cycle corner
// sequences, and randomized traffic checked against an integer-level model.
module tb_mux8_rr_arbiter;
    import mux8_arb_pkg::*;

    localparam int HOLD_MAX = 4;
    localparam int W        = 18;   // {state, hold[4], grant[8], S[3], Y, y_valid}

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  req;
    logic        last;
    logic [7:0]  I;
    logic [7:0]  grant;
    logic [2:0]  S;
    logic        Y;
    logic        y_valid;
    logic        state_dbg;
    logic [3:0]  hold_cnt_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];

    typedef struct packed {
        logic [7:0] req;
        logic       last;
        logic [7:0] din;
        logic [7:0] exp_grant;
        logic [2:0] exp_s;
        logic       exp_y;
        logic       exp_yv;
    } vec_t;

    vec_t vecs[11];

    // Integer-level reference model state
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_cnt;
    int m_sel;
    bit m_y;
    bit m_yv;

    mux8_rr_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .last         (last),
        .I            (I),
        .grant        (grant),
        .S            (S),
        .Y            (Y),
        .y_valid      (y_valid),
        .state_dbg    (state_dbg),
        .hold_cnt_dbg (hold_cnt_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic [7:0] r, input logic l, input logic [7:0] d);
        req  = r;
        last = l;
        I    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        last  = 1'b0;
        I     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_s", 32'(S), 32'h0);
        check("rst_y", 32'(Y), 32'h0);
        check("rst_yv", 32'(y_valid), 32'h0);
        check("rst_state", 32'(state_dbg), 32'h0);
        check("rst_hold", 32'(hold_cnt_dbg), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        m_sel   = 0;
        m_y     = 0;
        m_yv    = 0;
    endtask

    // Advance the model by one clock edge, using the inputs present at that edge.
    task automatic model_step(input logic [7:0] r, input logic l, input logic [7:0] d);
        bit         new_y;
        bit         new_yv;
        bit         rearb;
        logic [7:0] cands;
        logic [7:0] owner_bit;
        int         winner;
        new_y     = m_y;
        new_yv    = 0;
        rearb     = 0;
        cands     = r;
        owner_bit = '0;
        if (m_busy) begin
            new_y  = d[m_sel];
            new_yv = 1;
            owner_bit[m_owner] = 1'b1;
            if (l || !r[m_owner]) begin
                rearb = 1;
                cands = r & ~owner_bit;
            end else if (m_cnt == HOLD_MAX && (r & ~owner_bit) != 0) begin
                rearb = 1;
                cands = r;
            end else begin
                m_cnt = (m_cnt == HOLD_MAX) ? 1 : m_cnt + 1;
            end
        end
        if (!m_busy || rearb) begin
            winner = -1;
            for (int k = 0; k < 8; k++) begin
                int c;
                c = (m_ptr + k) % 8;
                if (winner < 0 && cands[c]) winner = c;
            end
            if (winner >= 0) begin
                m_busy  = 1;
                m_owner = winner;
                m_sel   = winner;
                m_ptr   = (winner + 1) % 8;
                m_cnt   = 1;
            end else begin
                m_busy = 0;
                m_cnt  = 0;
            end
        end
        m_y  = new_y;
        m_yv = new_yv;
    endtask

    function automatic logic [W-1:0] model_pack();
        logic [7:0] g;
        g = '0;
        if (m_busy) g[m_owner] = 1'b1;
        return {m_busy, 4'(m_cnt), g, 3'(m_sel), m_y, m_yv};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        req   = '0;
        last  = 1'b0;
        I     = '0;

        vecs[0]  = '{8'h00, 1'b0, 8'hAA, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{8'h04, 1'b0, 8'hAA, 8'h04, 3'd2, 1'b0, 1'b0};
        vecs[2]  = '{8'h04, 1'b0, 8'hAA, 8'h04, 3'd2, 1'b0, 1'b1};
        vecs[3]  = '{8'h04, 1'b0, 8'hFF, 8'h04, 3'd2, 1'b1, 1'b1};
        vecs[4]  = '{8'h04, 1'b1, 8'h00, 8'h00, 3'd2, 1'b0, 1'b1};
        vecs[5]  = '{8'h00, 1'b0, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0};
        vecs[6]  = '{8'h81, 1'b0, 8'h80, 8'h80, 3'd7, 1'b0, 1'b0};
        vecs[7]  = '{8'h81, 1'b1, 8'h80, 8'h01, 3'd0, 1'b1, 1'b1};
        vecs[8]  = '{8'h81, 1'b1, 8'h01, 8'h80, 3'd7, 1'b1, 1'b1};
        vecs[9]  = '{8'h00, 1'b0, 8'h00, 8'h00, 3'd7, 1'b0, 1'b1};
        vecs[10] = '{8'h00, 1'b0, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0};

        // Idle after reset: nothing granted, no valid data
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(8'h00, 1'b0, 8'h00);
            check($sformatf("idle_grant[%0d]", c), 32'(grant), 32'h0);
            check($sformatf("idle_s[%0d]", c), 32'(S), 32'h0);
            check($sformatf("idle_yv[%0d]", c), 32'(y_valid), 32'h0);
        end

        // Directed vector table, continuing from the idle state
        for (int v = 0; v < 11; v++) begin
            drive(vecs[v].req, vecs[v].last, vecs[v].din);
            check($sformatf("vec%0d_grant", v), 32'(grant), 32'(vecs[v].exp_grant));
            check($sformatf("vec%0d_s", v), 32'(S), 32'(vecs[v].exp_s));
            check($sformatf("vec%0d_y", v), 32'(Y), 32'(vecs[v].exp_y));
            check($sformatf("vec%0d_yv", v), 32'(y_valid), 32'(vecs[v].exp_yv));
        end

        // Hold limit: two persistent requesters swap every HOLD_MAX cycles
        do_reset();
        for (int c = 0; c < 3 * HOLD_MAX; c++) begin
            drive(8'h03, 1'b0, 8'h00);
            check($sformatf("holdlim_grant[%0d]", c), 32'(grant),
                  ((c / HOLD_MAX) % 2 == 1) ? 32'h02 : 32'h01);
        end

        // Lone holder keeps the grant; its counter wraps back to 1
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive(8'h08, 1'b0, 8'h00);
            check($sformatf("lone_grant[%0d]", c), 32'(grant), 32'h08);
            check($sformatf("lone_hold[%0d]", c), 32'(hold_cnt_dbg), 32'((c % HOLD_MAX) + 1));
        end

        // Reset asserted mid-grant clears outputs without a clock edge
        do_reset();
        drive(8'h20, 1'b0, 8'hFF);
        check("midrst_pre_grant", 32'(grant), 32'h20);
        drive(8'h20, 1'b0, 8'hFF);
        check("midrst_pre_yv", 32'(y_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_grant", 32'(grant), 32'h0);
        check("midrst_yv", 32'(y_valid), 32'h0);
        check("midrst_s", 32'(S), 32'h0);
        req = 8'hFF;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_first_grant", 32'(grant), 32'h01);
        check("midrst_first_s", 32'(S), 32'h0);

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        begin
            logic [7:0] r;
            logic       l;
            logic [7:0] d;
            logic [W-1:0] exp_v;
            logic [W-1:0] act_v;
            r = '0;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 3) == 0)
                    r = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
                l = ($urandom_range(0, 7) == 0);
                d = 8'($urandom_range(0, 255));
                model_step(r, l, d);
                exp_q.push_back(model_pack());
                drive(r, l, d);
                exp_v = exp_q.pop_front();
                act_v = {state_dbg, hold_cnt_dbg, grant, S, Y, y_valid};
                check($sformatf("rand[%0d]", i), 32'(act_v), 32'(exp_v));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
